// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of a 5-stage MIPS pipeline.
// Holds the PC, selects the next PC, drives the instruction-memory address
// and holds the IF/ID pipeline register. Hazard controls (pc_write,
// ifid_write, ifid_flush) stall, redirect and flush the stage.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_write,
   input  logic        ifid_write,
   input  logic        ifid_flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic [31:0] imem_rdata,
   output logic [31:0] imem_addr,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_fetch_cnt
);

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_pc4_q, ifid_pc4_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_valid_q, ifid_valid_d;

   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        run;

   // Target low bits are forced to zero, so they are intentionally unused.
   logic unused_target_lsbs;
   assign unused_target_lsbs = ^{jump_target[1:0], branch_target[1:0]};

   assign run       = (state_q == RUN);
   assign pc_plus4  = pc_q + 32'd4;   // 32-bit modulo: 0xFFFF_FFFC wraps to 0
   assign imem_addr = pc_q;

   // Next-state and next-PC selection: jump beats branch beats sequential.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
      state_d = RUN;  // BOOT lasts exactly one cycle; only reset leaves RUN
      next_pc = pc_plus4;
      pc_d    = pc_q;
      if (jump) begin
         next_pc = {jump_target[31:2], 2'b00};
      end else if (branch_taken) begin
         next_pc = {branch_target[31:2], 2'b00};
      end
      // A redirect seen while pc_write=0 is dropped; upstream reasserts it.
      if (run && pc_write) begin
         pc_d = next_pc;
      end
   end

   // IF/ID register next value: flush beats write beats hold; frozen in BOOT.
   always_comb begin
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      if (run) begin
         if (ifid_flush) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            ifid_pc4_d   = pc_plus4;
         end else if (ifid_write) begin
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            ifid_pc4_d   = pc_plus4;
         end
      end
   end

   // State, PC and IF/ID registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         ifid_pc4_q   <= 32'h0;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign ifid_pc4   = ifid_pc4_q;
   assign ifid_instr = ifid_instr_q;
   assign ifid_valid = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   // Saturating event counters, active in RUN only.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      fetch_cnt_d = fetch_cnt_q;
      if (run) begin
         if (!pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
         if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
         end
         if (!ifid_flush && ifid_write && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
         end
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
         fetch_cnt_q <= 32'h0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
   assign perf_fetch_cnt = fetch_cnt_q;
`else
   assign perf_stall_cnt = 32'h0;
   assign perf_flush_cnt = 32'h0;
   assign perf_fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, scoreboard-checked bench for fetch_stage.
// Expected post-edge state is computed from a behavioural model when each
// cycle's stimulus is driven, queued, and compared once the edge has passed.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] TAG       = 32'hA000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pc_write, ifid_write, ifid_flush;
   logic        branch_taken, jump;
   logic [31:0] branch_target, jump_target;
   logic [31:0] imem_rdata, imem_addr;
   logic [31:0] ifid_pc4, ifid_instr;
   logic        ifid_valid;
   logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_fetch_cnt;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        valid;
      logic [31:0] stall;
      logic [31:0] flush;
      logic [31:0] fetch;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state
   logic        m_run;
   logic [31:0] m_pc, m_pc4, m_instr;
   logic        m_valid;
   logic [31:0] m_stall, m_flush, m_fetch;

   always #5 clk = ~clk;

   // Combinational instruction memory: the word encodes its own address.
   assign imem_rdata = imem_addr | TAG;

   fetch_stage #(
      .RESET_PC (RESET_PC),
      .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_write      (pc_write),
      .ifid_write    (ifid_write),
      .ifid_flush    (ifid_flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_rdata    (imem_rdata),
      .imem_addr     (imem_addr),
      .ifid_pc4      (ifid_pc4),
      .ifid_instr    (ifid_instr),
      .ifid_valid    (ifid_valid),
      .perf_stall_cnt(perf_stall_cnt),
      .perf_flush_cnt(perf_flush_cnt),
      .perf_fetch_cnt(perf_fetch_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Drive one cycle of stimulus, queue the model's post-edge prediction,
   // advance one edge and compare the DUT against the popped prediction.
   task automatic cycle(input logic rst, input logic pw, input logic iw, input logic fl,
                        input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
      logic [31:0] pc4;
      exp_t e;
      rst_n = rst; pc_write = pw; ifid_write = iw; ifid_flush = fl;
      branch_taken = br; branch_target = bt; jump = j; jump_target = jt;

      if (!rst) begin
         m_run = 1'b0; m_pc = RESET_PC; m_pc4 = 32'h0; m_instr = NOP_INSTR; m_valid = 1'b0;
         m_stall = 32'h0; m_flush = 32'h0; m_fetch = 32'h0;
      end else if (!m_run) begin
         m_run = 1'b1;
      end else begin
         pc4 = m_pc + 32'd4;
         if (!pw) m_stall = sat_inc(m_stall);
         if (fl) m_flush = sat_inc(m_flush);
         if (!fl && iw) m_fetch = sat_inc(m_fetch);
         if (fl) begin
            m_instr = NOP_INSTR; m_valid = 1'b0; m_pc4 = pc4;
         end else if (iw) begin
            m_instr = m_pc | TAG; m_valid = 1'b1; m_pc4 = pc4;
         end
         if (pw) begin
            if (j)       m_pc = {jt[31:2], 2'b00};
            else if (br) m_pc = {bt[31:2], 2'b00};
            else         m_pc = pc4;
         end
      end

`ifdef FETCH_PERF_CNT_EN
      sb_q.push_back('{m_pc, m_pc4, m_instr, m_valid, m_stall, m_flush, m_fetch});
`else
      sb_q.push_back('{m_pc, m_pc4, m_instr, m_valid, 32'h0, 32'h0, 32'h0});
`endif

      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("imem_addr", imem_addr, e.pc);
      check("ifid_pc4", ifid_pc4, e.pc4);
      check("ifid_instr", ifid_instr, e.instr);
      check("ifid_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
      check("perf_stall", perf_stall_cnt, e.stall);
      check("perf_flush", perf_flush_cnt, e.flush);
      check("perf_fetch", perf_fetch_cnt, e.fetch);
   endtask

   // Shorthands for common cycle shapes
   task automatic run_seq();
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Global time limit so a hung run still ends with a failure report.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; pc_write = 1'b0; ifid_write = 1'b0; ifid_flush = 1'b0;
      branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;

      // Reset for two cycles
      do_reset();
      do_reset();
      check("rst_pc", imem_addr, RESET_PC);
      check("rst_valid", {31'h0, ifid_valid}, 32'h0);

      // BOOT: redirects, stalls and flushes are ignored
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h100);
      check("boot_pc", imem_addr, 32'h0);

      // Sequential fetch
      run_seq();
      check("seq_pc", imem_addr, 32'h4);
      check("seq_instr0", ifid_instr, 32'hA000_0000);
      check("seq_pc4_0", ifid_pc4, 32'h4);
      run_seq();   // pc=8

      // Load-use stall at pc=8
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("stall_pc", imem_addr, 32'h8);
      check("stall_instr", ifid_instr, 32'hA000_0004);
      run_seq();   // pc=12, IF/ID <- instr@8
      check("resume_pc", imem_addr, 32'hC);
      run_seq();   // pc=16

      // Branch taken with flush
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
      check("br_pc", imem_addr, 32'h40);
      check("br_bubble", ifid_instr, NOP_INSTR);
      run_seq();
      check("br_instr", ifid_instr, 32'hA000_0040);
      check("br_pc4", ifid_pc4, 32'h44);

      // Jump beats branch; misaligned jump target is aligned
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h100);
      check("jmp_pc", imem_addr, 32'h100);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h103);
      check("jmp_align", imem_addr, 32'h100);

      // Redirect during stall is dropped
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
      check("drop_redir", imem_addr, 32'h100);

      // Flush with PC held
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check("flush_hold", imem_addr, 32'h100);

      // PC wrap at the top of the address space
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      run_seq();
      check("wrap_pc", imem_addr, 32'h0);
      check("wrap_pc4", ifid_pc4, 32'h0);

      // Reset asserted mid-stall with a pending redirect
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
      check("mid_rst_pc", imem_addr, RESET_PC);
      check("mid_rst_stall", perf_stall_cnt, 32'h0);

      // Perf sequence: BOOT activity must not count
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) run_seq();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("perf_stall_total", perf_stall_cnt, 32'd3);
      check("perf_flush_total", perf_flush_cnt, 32'd2);
      check("perf_fetch_total", perf_fetch_cnt, 32'd5);
`else
      check("perf_stall_off", perf_stall_cnt, 32'd0);
      check("perf_flush_off", perf_flush_cnt, 32'd0);
      check("perf_fetch_off", perf_fetch_cnt, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
